rob_client_arbiter: RTL and testbench
=====================================

# rob_client_arbiter

Front-end arbiter that shares one reorder-buffer request/response port among NCLI independent clients. Requests are granted round-robin, staged in a one-entry output register and issued to the ROB; the granted client index is pushed into an in-order tracking FIFO. The ROB returns responses in request order, so each response is routed to the client at the FIFO head.

## Interface
Parameters:
- NCLI, 4, number of clients (2..16)
- DEPTH, 128, tracking FIFO depth; set equal to the ROB's ROB_SIZE
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- PWIDTH, 10, request parameter width
- IDWIDTH, 16, request ID width

Ports:
- clk  in  1  clock
- rst_  in  1  one clock; reset is synchronous and active-high (rst_ = 1 resets)
- cli_req_val  in  NCLI  per-client request valid
- cli_req_addr  in  NCLI*AWIDTH  client c at bits [c*AWIDTH +: AWIDTH]
- cli_req_ID  in  NCLI*IDWIDTH  packed as above
- cli_req_param  in  NCLI*PWIDTH  packed as above
- cli_req_ready  out  NCLI  one-hot grant/accept
- cli_rsp_val  out  NCLI  one-hot response valid
- cli_rsp_data  out  DWIDTH  broadcast response data
- cli_rsp_ID  out  IDWIDTH  broadcast response ID
- cli_rsp_param  out  PWIDTH  broadcast response param
- cli_rsp_ready  in  NCLI  per-client response ready
- rob_req_val, rob_req_addr, rob_req_ID, rob_req_param  out  1/AWIDTH/IDWIDTH/PWIDTH  ROB request
- rob_req_ready  in  1  ROB accepts
- rob_rsp_val, rob_rsp_data, rob_rsp_ID, rob_rsp_param  in  1/DWIDTH/IDWIDTH/PWIDTH  ROB response
- rob_rsp_ready  out  1  arbiter accepts response
- outstanding  out  $clog2(DEPTH+1)  tracking FIFO occupancy
- err  out  1  sticky: response arrived with FIFO empty

## Operation
- Output stage: register `stg_val` plus payload. It drains when `rob_req_val & rob_req_ready`.
- Grant is allowed when `(!stg_val | rob_req_ready)` and `outstanding < DEPTH`, using the registered count.
  - A pop in the same cycle does not unblock a full FIFO.
- Round-robin: pointer `last`. Priority is `last+1, last+2, …` modulo NCLI.
  - `cli_req_ready[c]` = allowed and c is the highest-priority requester.
  - On grant: `last <= c`, load the stage register, push c into the FIFO.
- Response routing: head = FIFO head index.
  - `cli_rsp_val[head] = rob_rsp_val & !empty`.
  - `rob_rsp_ready = cli_rsp_ready[head]` when not empty.
  - Pop on `rob_rsp_val & rob_rsp_ready`.
- Empty FIFO with `rob_rsp_val`: set `rob_rsp_ready = 1`, drop the response, set `err`. `err` clears only on reset.
- Simultaneous push and pop: `outstanding` unchanged; both take effect.
- Response data, ID and param are combinational pass-through from the ROB.

## Timing
- Reset values: `rob_req_val=0`, payload 0, `cli_req_ready=0`, `cli_rsp_val=0`, `rob_rsp_ready=0`, `outstanding=0`, `err=0`, `last=NCLI-1` (client 0 wins first).
- Request latency: `rob_req_val` is asserted in the cycle after the client handshake.
- Throughput: 1 request/cycle while `rob_req_ready=1`.
- Payload stays stable while `rob_req_val & !rob_req_ready`.
- Response path: 0 cycles, fully combinational.
- Reset mid-operation: the stage register and FIFO are flushed. The ROB must be reset together with this block.

## Structure
- Package `rob_arb_pkg`:
  - `CIDX_W = $clog2(NCLI)` helper function
  - packed request struct typedef (addr/ID/param)
- Sub-module `rob_arb_fifo`:
  - synchronous FIFO of CIDX_W-bit entries, depth DEPTH
  - push/pop, head, count, full/empty
  - registered count; same-cycle push and pop allowed

## Test plan
- Reset, then client 2 requests addr 0x10, ID 5, `rob_req_ready=1` → `rob_req_val` asserted the next cycle with addr 0x10, ID 5; `outstanding=1`.
- All 4 clients hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3, one per cycle; `outstanding=8`.
- `rob_req_ready=0` for 5 cycles with client 1 requesting → one request staged, payload stable, no further grants, `outstanding=1`.
- DEPTH=4, 6 requests, no responses → exactly 4 grants; `cli_req_ready` stays 0 until one response pops, then one more grant the following cycle.
- Grants to clients 3,0,3; ROB returns 3 responses (data 7,8,9) → `cli_rsp_val` one-hot 3,0,3 with data 7,8,9. Holding `cli_rsp_ready[0]=0` stalls `rob_rsp_ready`.
- `rob_rsp_val` with FIFO empty → `rob_rsp_ready=1`, no `cli_rsp_val`, `err=1` until reset.

Source files
------------

// File: rtl/rob_arb_pkg.sv
// Shared types and helpers for the ROB client arbiter.
package rob_arb_pkg;

  function automatic int cidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AWIDTH_DEF  = 32;
  localparam int IDWIDTH_DEF = 16;
  localparam int PWIDTH_DEF  = 10;

  typedef struct packed {
    logic [AWIDTH_DEF-1:0]  addr;
    logic [IDWIDTH_DEF-1:0] id;
    logic [PWIDTH_DEF-1:0]  param;
  } rob_req_t;

endpackage

// File: rtl/rob_arb_fifo.sv
// In-order tracking FIFO holding the client index of every request issued to the ROB.
module rob_arb_fifo
  import rob_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 128,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    head,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNTW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = inc(wr_ptr_q);
    end
    if (pop_ok) rd_ptr_d = inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/rob_client_arbiter.sv
// Round-robin arbiter sharing one ROB request/response port among NCLI clients;
// responses return in order and are steered by the tracking FIFO head.
module rob_client_arbiter
  import rob_arb_pkg::*;
#(
  parameter int NCLI    = 4,
  parameter int DEPTH   = 128,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int PWIDTH  = 10,
  parameter int IDWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [NCLI-1:0]            cli_req_val,
  input  logic [NCLI*AWIDTH-1:0]     cli_req_addr,
  input  logic [NCLI*IDWIDTH-1:0]    cli_req_ID,
  input  logic [NCLI*PWIDTH-1:0]     cli_req_param,
  output logic [NCLI-1:0]            cli_req_ready,
  output logic [NCLI-1:0]            cli_rsp_val,
  output logic [DWIDTH-1:0]          cli_rsp_data,
  output logic [IDWIDTH-1:0]         cli_rsp_ID,
  output logic [PWIDTH-1:0]          cli_rsp_param,
  input  logic [NCLI-1:0]            cli_rsp_ready,
  output logic                       rob_req_val,
  output logic [AWIDTH-1:0]          rob_req_addr,
  output logic [IDWIDTH-1:0]         rob_req_ID,
  output logic [PWIDTH-1:0]          rob_req_param,
  input  logic                       rob_req_ready,
  input  logic                       rob_rsp_val,
  input  logic [DWIDTH-1:0]          rob_rsp_data,
  input  logic [IDWIDTH-1:0]         rob_rsp_ID,
  input  logic [PWIDTH-1:0]          rob_rsp_param,
  output logic                       rob_rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);
  localparam int CW = cidx_w(NCLI);
  localparam int OW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AWIDTH-1:0]  addr;
    logic [IDWIDTH-1:0] id;
    logic [PWIDTH-1:0]  param;
  } req_t;

  logic          stg_val_q, stg_val_d;
  req_t          stg_q, stg_d;
  logic [CW-1:0] last_q, last_d;
  logic          err_q, err_d;
  logic [CW-1:0] win, head;
  logic          found, allowed, grant, pop;
  logic          fifo_full, fifo_empty;
  logic [OW-1:0] fifo_count;

  // First requester after the last winner, wrapping modulo NCLI.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCLI; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NCLI) idx = idx - NCLI;
      if (!found && cli_req_val[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
  end

  // Registered count only: a same-cycle pop does not free a slot.
  assign allowed       = ~rst_ & (~stg_val_q | rob_req_ready) & ~fifo_full;
  assign grant         = allowed & found;
  assign cli_req_ready = grant ? (NCLI'(1) << win) : '0;

  always_comb begin
    stg_val_d = stg_val_q;
    stg_d     = stg_q;
    last_d    = last_q;
    if (grant) begin
      stg_val_d   = 1'b1;
      stg_d.addr  = cli_req_addr[int'(win)*AWIDTH +: AWIDTH];
      stg_d.id    = cli_req_ID[int'(win)*IDWIDTH +: IDWIDTH];
      stg_d.param = cli_req_param[int'(win)*PWIDTH +: PWIDTH];
      last_d      = win;
    end else if (rob_req_ready) begin
      stg_val_d = 1'b0;
    end
  end

  assign rob_req_val   = stg_val_q;
  assign rob_req_addr  = stg_q.addr;
  assign rob_req_ID    = stg_q.id;
  assign rob_req_param = stg_q.param;

  // An orphan response is swallowed so the ROB never wedges; err records it.
  assign rob_rsp_ready = fifo_empty ? rob_rsp_val : cli_rsp_ready[head];
  assign cli_rsp_val   = (rob_rsp_val & ~fifo_empty) ? (NCLI'(1) << head) : '0;
  assign pop           = rob_rsp_val & rob_rsp_ready & ~fifo_empty;
  assign err_d         = err_q | (rob_rsp_val & fifo_empty);

  assign cli_rsp_data  = rob_rsp_data;
  assign cli_rsp_ID    = rob_rsp_ID;
  assign cli_rsp_param = rob_rsp_param;
  assign outstanding   = fifo_count;
  assign err           = err_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      stg_val_q <= 1'b0;
      stg_q     <= '0;
      last_q    <= CW'(NCLI - 1);
      err_q     <= 1'b0;
    end else begin
      stg_val_q <= stg_val_d;
      stg_q     <= stg_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  rob_arb_fifo #(.W(CW), .DEPTH(DEPTH), .CNTW(OW)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (grant),
    .din   (win),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_rob_client_arbiter.sv
// Directed plus randomized bench for rob_client_arbiter against a queue-based model.
module tb_rob_client_arbiter;
  localparam int NCLI = 4, DEPTH = 8, AW = 16, DW = 16, PW = 4, IW = 8;
  localparam int OW = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_;
  logic [NCLI-1:0]      cli_req_val;
  logic [NCLI*AW-1:0]   cli_req_addr;
  logic [NCLI*IW-1:0]   cli_req_ID;
  logic [NCLI*PW-1:0]   cli_req_param;
  logic [NCLI-1:0]      cli_req_ready;
  logic [NCLI-1:0]      cli_rsp_val;
  logic [DW-1:0]        cli_rsp_data;
  logic [IW-1:0]        cli_rsp_ID;
  logic [PW-1:0]        cli_rsp_param;
  logic [NCLI-1:0]      cli_rsp_ready;
  logic                 rob_req_val;
  logic [AW-1:0]        rob_req_addr;
  logic [IW-1:0]        rob_req_ID;
  logic [PW-1:0]        rob_req_param;
  logic                 rob_req_ready;
  logic                 rob_rsp_val;
  logic [DW-1:0]        rob_rsp_data;
  logic [IW-1:0]        rob_rsp_ID;
  logic [PW-1:0]        rob_rsp_param;
  logic                 rob_rsp_ready;
  logic [OW-1:0]        outstanding;
  logic                 err;

  always #5 clk = ~clk;

  rob_client_arbiter #(.NCLI(NCLI), .DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW),
                       .PWIDTH(PW), .IDWIDTH(IW)) dut (
    .clk(clk), .rst_(rst_),
    .cli_req_val(cli_req_val), .cli_req_addr(cli_req_addr), .cli_req_ID(cli_req_ID),
    .cli_req_param(cli_req_param), .cli_req_ready(cli_req_ready),
    .cli_rsp_val(cli_rsp_val), .cli_rsp_data(cli_rsp_data), .cli_rsp_ID(cli_rsp_ID),
    .cli_rsp_param(cli_rsp_param), .cli_rsp_ready(cli_rsp_ready),
    .rob_req_val(rob_req_val), .rob_req_addr(rob_req_addr), .rob_req_ID(rob_req_ID),
    .rob_req_param(rob_req_param), .rob_req_ready(rob_req_ready),
    .rob_rsp_val(rob_rsp_val), .rob_rsp_data(rob_rsp_data), .rob_rsp_ID(rob_rsp_ID),
    .rob_rsp_param(rob_rsp_param), .rob_rsp_ready(rob_rsp_ready),
    .outstanding(outstanding), .err(err)
  );

  int checks = 0, failures = 0;

  // Model: round-robin pointer, queue of outstanding client indices, staged request.
  int            m_last;
  int            m_q[$];
  bit            m_stg_val;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  logic [PW-1:0] m_param;
  bit            m_err;

  logic [NCLI-1:0] obs_rdy, obs_rsp;
  logic            obs_rrdy;
  logic [DW-1:0]   obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = NCLI - 1;
    m_q.delete();
    m_stg_val = 0;
    m_addr = '0; m_id = '0; m_param = '0;
    m_err = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic [NCLI-1:0] exp_rdy, exp_rsp;
    bit allowed, exp_rrdy;
    int gc, h;
    #1;
    obs_rdy = cli_req_ready; obs_rsp = cli_rsp_val;
    obs_rrdy = rob_rsp_ready; obs_data = cli_rsp_data;
    allowed = !rst_ && (!m_stg_val || rob_req_ready) && (m_q.size() < DEPTH);
    gc = -1;
    for (int k = 1; k <= NCLI; k++) begin
      int c = (m_last + k) % NCLI;
      if (gc < 0 && cli_req_val[c]) gc = c;
    end
    if (!allowed) gc = -1;
    exp_rdy = (gc >= 0) ? (NCLI'(1) << gc) : '0;
    if (m_q.size() == 0) begin
      exp_rsp = '0;
      exp_rrdy = rob_rsp_val;
    end else begin
      h = m_q[0];
      exp_rsp = rob_rsp_val ? (NCLI'(1) << h) : '0;
      exp_rrdy = cli_rsp_ready[h];
    end
    chk("cli_req_ready", 64'(obs_rdy), 64'(exp_rdy));
    chk("rob_req_val", 64'(rob_req_val), 64'(m_stg_val));
    if (m_stg_val) begin
      chk("rob_req_addr", 64'(rob_req_addr), 64'(m_addr));
      chk("rob_req_ID", 64'(rob_req_ID), 64'(m_id));
      chk("rob_req_param", 64'(rob_req_param), 64'(m_param));
    end
    chk("cli_rsp_val", 64'(obs_rsp), 64'(exp_rsp));
    chk("rob_rsp_ready", 64'(obs_rrdy), 64'(exp_rrdy));
    chk("outstanding", 64'(outstanding), 64'(m_q.size()));
    chk("err", 64'(err), 64'(m_err));
    if (rob_rsp_val) begin
      chk("cli_rsp_data", 64'(obs_data), 64'(rob_rsp_data));
      chk("cli_rsp_ID", 64'(cli_rsp_ID), 64'(rob_rsp_ID));
      chk("cli_rsp_param", 64'(cli_rsp_param), 64'(rob_rsp_param));
    end
    if (rst_) model_reset();
    else begin
      if (rob_rsp_val && m_q.size() == 0) m_err = 1;
      else if (rob_rsp_val && exp_rrdy) void'(m_q.pop_front());
      if (gc >= 0) begin
        m_stg_val = 1;
        m_addr  = cli_req_addr[gc*AW +: AW];
        m_id    = cli_req_ID[gc*IW +: IW];
        m_param = cli_req_param[gc*PW +: PW];
        m_last  = gc;
        m_q.push_back(gc);
      end else if (rob_req_ready) m_stg_val = 0;
    end
    @(negedge clk);
  endtask

  task automatic clr();
    cli_req_val = '0; cli_req_addr = '0; cli_req_ID = '0; cli_req_param = '0;
    cli_rsp_ready = '0; rob_req_ready = 0; rob_rsp_val = 0;
    rob_rsp_data = '0; rob_rsp_ID = '0; rob_rsp_param = '0;
  endtask

  task automatic set_req(input int c, input logic [AW-1:0] a, input logic [IW-1:0] id,
                         input logic [PW-1:0] p);
    cli_req_val[c] = 1'b1;
    cli_req_addr[c*AW +: AW] = a;
    cli_req_ID[c*IW +: IW] = id;
    cli_req_param[c*PW +: PW] = p;
  endtask

  task automatic do_reset();
    clr();
    rst_ = 1;
    cycle();
    chk("rst_rob_req_val", 64'(rob_req_val), 64'd0);
    chk("rst_rob_req_addr", 64'(rob_req_addr), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cli_req_ready", 64'(cli_req_ready), 64'd0);
    rst_ = 0;
  endtask

  initial begin
    clr();
    rst_ = 1;
    @(negedge clk);
    model_reset();

    // Single request from client 2
    do_reset();
    rob_req_ready = 1;
    set_req(2, 16'h0010, 8'd5, 4'd3);
    cycle();
    chk("t1_ready", 64'(obs_rdy), 64'b0100);
    clr(); rob_req_ready = 1;
    chk("t1_val", 64'(rob_req_val), 64'd1);
    chk("t1_addr", 64'(rob_req_addr), 64'h10);
    chk("t1_id", 64'(rob_req_ID), 64'd5);
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    cycle();

    // All clients request: strict 0,1,2,3 rotation until the FIFO fills
    do_reset();
    rob_req_ready = 1;
    for (int c = 0; c < NCLI; c++) set_req(c, AW'(16'h100 + c), IW'(c), PW'(c));
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t2_order", 64'(obs_rdy), 64'(1) << (i % 4));
    end
    chk("t2_outstanding", 64'(outstanding), 64'd8);
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t2_full_block", 64'(obs_rdy), 64'd0);
    end
    rob_rsp_val = 1; rob_rsp_data = 16'h55; cli_rsp_ready = '1;
    cycle();
    chk("t2_pop_no_grant", 64'(obs_rdy), 64'd0);
    chk("t2_pop_route", 64'(obs_rsp), 64'b0001);
    rob_rsp_val = 0;
    cycle();
    chk("t2_regrant", 64'(obs_rdy), 64'b0001);
    chk("t2_refull", 64'(outstanding), 64'd8);

    // Back-pressure holds one staged request
    do_reset();
    set_req(1, 16'hBEEF, 8'hA5, 4'd9);
    for (int i = 0; i < 5; i++) cycle();
    chk("t3_outstanding", 64'(outstanding), 64'd1);
    chk("t3_val", 64'(rob_req_val), 64'd1);
    chk("t3_addr", 64'(rob_req_addr), 64'hBEEF);

    // Grants 3,0,3 then in-order responses 7,8,9 with a stall on client 0
    do_reset();
    rob_req_ready = 1; set_req(3, 16'h1, 8'd1, 4'd1); cycle();
    clr(); rob_req_ready = 1; set_req(0, 16'h2, 8'd2, 4'd2); cycle();
    clr(); rob_req_ready = 1; set_req(3, 16'h3, 8'd3, 4'd3); cycle();
    clr(); rob_req_ready = 1; cycle();
    cli_rsp_ready = '1; rob_rsp_val = 1; rob_rsp_data = 16'd7; cycle();
    chk("t4_rsp0", 64'(obs_rsp), 64'b1000);
    chk("t4_data0", 64'(obs_data), 64'd7);
    cli_rsp_ready = 4'b1110; rob_rsp_data = 16'd8; cycle();
    chk("t4_stall", 64'(obs_rrdy), 64'd0);
    chk("t4_stall_val", 64'(obs_rsp), 64'b0001);
    cli_rsp_ready = '1; cycle();
    chk("t4_rsp1", 64'(obs_rsp), 64'b0001);
    chk("t4_data1", 64'(obs_data), 64'd8);
    rob_rsp_data = 16'd9; cycle();
    chk("t4_rsp2", 64'(obs_rsp), 64'b1000);
    chk("t4_data2", 64'(obs_data), 64'd9);
    rob_rsp_val = 0; cycle();
    chk("t4_drained", 64'(outstanding), 64'd0);

    // Orphan response: swallowed, err sticks until reset
    do_reset();
    rob_rsp_val = 1; rob_rsp_data = 16'h77; cycle();
    chk("t5_rrdy", 64'(obs_rrdy), 64'd1);
    chk("t5_no_rsp", 64'(obs_rsp), 64'd0);
    rob_rsp_val = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_err_sticky", 64'(err), 64'd1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cli_req_val = NCLI'($urandom);
      cli_req_addr = (NCLI*AW)'({$urandom, $urandom});
      cli_req_ID = (NCLI*IW)'($urandom);
      cli_req_param = (NCLI*PW)'($urandom);
      rob_req_ready = ($urandom_range(0, 3) != 0);
      rob_rsp_val = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      rob_rsp_data = DW'($urandom);
      rob_rsp_ID = IW'($urandom);
      rob_rsp_param = PW'($urandom);
      cli_rsp_ready = NCLI'($urandom) | NCLI'($urandom);
      rst_ = ($urandom_range(0, 150) == 0);
      cycle();
    end
    rst_ = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
